// File: rtl/qsys_system_nios2_gen2_cpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu: one quotient bit per clock,
// start/busy/done handshake, pipeline-flush abort, signed fixup in a final FIX cycle.
module qsys_system_nios2_gen2_cpu_div_cell #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  E_start,
    input  logic [DATA_WIDTH-1:0] E_src1,
    input  logic [DATA_WIDTH-1:0] E_src2,
    input  logic                  E_signed,
    input  logic                  E_abort,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]         prem_q, prem_d;   // partial remainder
    logic [W-1:0]         dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [W-1:0]         dvs_q, dvs_d;
    logic [W-1:0]         src1_q, src1_d;   // original dividend, returned on divide by zero
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 zero_q, zero_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [W-1:0]         quo_q, quo_d;
    logic [W-1:0]         rmd_q, rmd_d;
    logic                 dbz_q, dbz_d;

    logic [W-1:0]         abs1, abs2;
    logic [W:0]           rem_sh, trial;

    // NOTE: every always_comb output is defaulted first so no path leaves a latch.
    always_comb begin
        abs1   = (E_signed && E_src1[W-1]) ? -E_src1 : E_src1;
        abs2   = (E_signed && E_src2[W-1]) ? -E_src2 : E_src2;
        rem_sh = {prem_q, dvd_q[W-1]};
        // rem < divisor keeps a non-negative trial below 2^W, so trial[W] is a true sign bit
        trial  = rem_sh - {1'b0, dvs_q};

        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        src1_d    = src1_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dbz_d     = dbz_q;

        if (E_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (E_start) begin
                        dvd_d     = abs1;
                        dvs_d     = abs2;
                        src1_d    = E_src1;
                        neg_quo_d = E_signed & (E_src1[W-1] ^ E_src2[W-1]);
                        neg_rem_d = E_signed & E_src1[W-1];
                        zero_d    = (E_src2 == '0);
                        prem_d    = '0;
                        cnt_d     = CNT_WIDTH'(W - 1);
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    dvd_d  = {dvd_q[W-2:0], ~trial[W]};
                    prem_d = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_FIX: begin
                    quo_d   = zero_q ? '1     : (neg_quo_q ? -dvd_q  : dvd_q);
                    rmd_d   = zero_q ? src1_q : (neg_rem_q ? -prem_q : prem_q);
                    dbz_d   = zero_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and wins over all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            prem_q    <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            src1_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prem_q    <= prem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            src1_q    <= src1_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_qsys_system_nios2_gen2_cpu_div_cell.sv
// Directed bench for the div cell: latency, signed/unsigned results, divide by zero,
// handshake rules, abort and mid-run reset.
module tb_qsys_system_nios2_gen2_cpu_div_cell;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [31:0] E_src1;
    logic [31:0] E_src2;
    logic        E_signed;
    logic        E_abort;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qsys_system_nios2_gen2_cpu_div_cell #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_start    (E_start),
        .E_src1     (E_src1),
        .E_src2     (E_src2),
        .E_signed   (E_signed),
        .E_abort    (E_abort),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge; on return the start has been sampled.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        E_src1   = a;
        E_src2   = b;
        E_signed = s;
        E_start  = 1'b1;
        tick();
        E_start  = 1'b0;
    endtask

    // Count edges until done is seen; -1 if it never comes within the budget.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; E_start = 1'b1; E_abort = 1'b0;
        E_src1 = 32'd5; E_src2 = 32'd1; E_signed = 1'b0;
        tick(); tick();
        reset = 1'b0; E_start = 1'b0;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b dbz=%b q=%h r=%h required all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
    endtask

    task automatic run_and_check(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic [31:0] eq, input logic [31:0] er,
                                 input logic edbz);
        int lat;
        issue(a, b, s);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_rise busy=%b required 1", name, busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL %s_latency got=%0d required 33", name, lat);
        end
        checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== edbz) begin
            failures++;
            $display("FAIL %s_result q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                     name, quotient, remainder, div_by_zero, eq, er, edbz);
        end
    endtask

    task automatic test_divu();
        run_and_check("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL done_pulse_hold done=%b busy=%b q=%h r=%h required done=0 busy=0 q=0000000e r=00000002",
                     done, busy, quotient, remainder);
        end
    endtask

    task automatic test_signed();
        run_and_check("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_and_check("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_and_check("div_m9_m4", 32'hFFFF_FFF7, 32'hFFFF_FFFC, 1'b1, 32'd2, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_range();
        run_and_check("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        run_and_check("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_and_check("divu_big", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1, 32'h7FFF_FFFF, 1'b0);
    endtask

    task automatic test_div_zero();
        run_and_check("divu_zero", 32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        run_and_check("div_zero_neg", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    endtask

    task automatic test_ignore_start();
        int lat;
        issue(32'd50, 32'd5, 1'b0);
        repeat (4) tick();
        issue(32'd1, 32'd1, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 28 || quotient !== 32'd10 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start lat=%0d q=%h r=%h dbz=%b required lat=28 q=0000000a r=00000000 dbz=0",
                     lat, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(32'd100, 32'd7, 1'b0);
        wait_done(lat);
        // Start held high in the done cycle must be accepted at the very next edge.
        issue(32'd20, 32'd3, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_no_bubble busy=%b required 1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 33 || quotient !== 32'd6 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL b2b_result lat=%0d q=%h r=%h required lat=33 q=00000006 r=00000002",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_abort();
        int seen;
        issue(32'd1000, 32'd10, 1'b0);
        repeat (9) tick();
        E_abort = 1'b1;
        tick();
        E_abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy busy=%b required 0", busy);
        end
        seen = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || quotient !== 32'd6 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold activity=%0d q=%h r=%h dbz=%b required activity=0 q=00000006 r=00000002 dbz=0",
                     seen, quotient, remainder, div_by_zero);
        end
        // Abort together with start in IDLE: the start must not be taken.
        E_abort = 1'b1;
        issue(32'd9, 32'd2, 1'b0);
        E_abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_blocks_start busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        run_and_check("divu_zero_pre", 32'd77, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd77, 1'b1);
        issue(32'd77, 32'd7, 1'b0);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b dbz=%b q=%h r=%h required all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        run_and_check("divu_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; E_start = 1'b0; E_abort = 1'b0;
        E_src1 = '0; E_src2 = '0; E_signed = 1'b0;
        #1;
        test_reset();
        test_divu();
        test_signed();
        test_range();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qsys_system_nios2_gen2_cpu_div_cell.md
Name: qsys_system_nios2_gen2_cpu_div_cell

Overview:
Iterative radix-2 restoring divider for the Nios II gen2 CPU execute/memory path. It is the inverse companion to the pipelined multiply cell and serves the div and divu instructions. It takes E-stage source operands, runs one quotient bit per clock, and returns the quotient and remainder with a done pulse. Issue is controlled by a start/busy/done handshake and a pipeline-flush abort.

Parameters:
DATA_WIDTH, 32, operand/result width; must be >= 2.
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
clk  input  1  rising-edge clock, single clock domain
reset  input  1  synchronous active-high reset
E_start  input  1  request a divide; sampled only when busy=0
E_src1  input  DATA_WIDTH  dividend, captured with E_start
E_src2  input  DATA_WIDTH  divisor, captured with E_start
E_signed  input  1  1=div (two's complement), 0=divu; captured with E_start
E_abort  input  1  pipeline flush; cancels any in-flight divide
busy  output  1  high while a divide is in progress (RUN or FIX)
done  output  1  one-cycle pulse; quotient/remainder valid this cycle and held afterward
quotient  output  DATA_WIDTH  result quotient
remainder  output  DATA_WIDTH  result remainder
div_by_zero  output  1  divisor was zero; valid with done, held afterward

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, reset).
- Reset state: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0. Reset wins over every other input in the same cycle.
- States:
  - IDLE: if E_start=1 and E_abort=0:
    - capture |src1| and |src2|; magnitudes are taken only when E_signed=1, otherwise raw values.
    - record neg_q = E_signed & (src1[MSB] ^ src2[MSB]) and neg_r = E_signed & src1[MSB].
    - record zero flag = (src2==0); clear partial remainder; counter=DATA_WIDTH-1; go to RUN.
  - RUN: each clock:
    - shift {rem, dvd} left by 1.
    - trial = rem_shifted - divisor, computed at DATA_WIDTH+1 bits.
    - if trial is non-negative, rem = trial and the quotient bit = 1; else the quotient bit = 0.
    - when counter==0, go to FIX; else decrement the counter.
  - FIX: apply signs (quotient negated if neg_q, remainder negated if neg_r, two's complement mod 2^DATA_WIDTH). Register the outputs, drive done=1 for this single cycle, go to IDLE.
- busy=1 in RUN and FIX, registered. done=1 only in the cycle after the FIX edge.
- Latency: E_start sampled at edge N gives done=1 in the cycle following edge N+DATA_WIDTH+1 (33 clocks for DATA_WIDTH=32).
- Back-to-back issue: E_start may be high in the same cycle done=1. It is accepted at the next edge with no bubble.
- E_start while busy=1: ignored; no queuing and no error.
- E_abort=1 in any state: state goes to IDLE at the next edge; busy=0; no done pulse; quotient/remainder/div_by_zero keep their previous values. E_abort with E_start in IDLE means the start is not accepted.
- Divide by zero (divisor==0, signed or unsigned):
  - quotient=all ones; remainder=original E_src1; div_by_zero=1.
  - timing is the same as a normal divide; the sign fixup is bypassed.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0, div_by_zero=0, with no trap.
- Sign convention: the quotient truncates toward zero; the remainder takes the sign of the dividend; src1 == quotient*src2 + remainder holds mod 2^DATA_WIDTH.
- Output hold: results and div_by_zero persist until the next FIX or reset.

Test Plan:
- divu 100/7 (E_signed=0): busy rises the cycle after start; done pulses exactly 33 clocks after start; quotient=14, remainder=2, div_by_zero=0.
- div -7/2 (0xFFFFFFF9 / 0x2, E_signed=1) gives quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also 7/-2 gives -3 rem 1.
- Overflow and full range:
  - div 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0.
  - divu 0xFFFFFFFF / 1 gives quotient=0xFFFFFFFF, remainder=0.
- Divide by zero: divu 0x1234 / 0 gives quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, with normal latency.
- Handshake:
  - a second E_start during RUN is ignored; the first result is unchanged.
  - E_start held in the done cycle: a new divide 20/3 begins with no bubble and returns 6 rem 2 at 33 clocks.
- Abort and reset:
  - E_abort 10 cycles into RUN: busy falls at the next edge, no done pulse, previous outputs are retained.
  - reset mid-RUN: all outputs are 0 the next cycle.
  - a subsequent 9/3 gives 3 rem 0.
